// File: rtl/seg_pkg.sv
// Shared constants for the 6-digit multiplexed 7-segment scanner.
// Segment codes are active-low {g,f,e,d,c,b,a}; the dp bit is added by the scanner.
// digit_nibble() selects digit k's BCD nibble from the packed {hr,mn,sd} word.
package seg_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int NIB_W      = 4;
    localparam int IDX_W      = 3;
    localparam int TM_W       = NUM_DIGITS * NIB_W;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // Digit k lives in word[4k+3:4k]; digit 0 is the seconds units.
    function automatic logic [NIB_W-1:0] digit_nibble(
        input logic [TM_W-1:0]  word,
        input logic [IDX_W-1:0] idx
    );
        logic [NIB_W-1:0] nib;
        nib = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                nib = word[k*NIB_W +: NIB_W];
            end
        end
        return nib;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// BCD nibble to active-low 7-segment decoder; values A..F show a dash (g only).
// Latency: combinational. Backpressure: none.
// Ports: nib_i (BCD nibble), seg_o (active-low {g,f,e,d,c,b,a}).
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [NIB_W-1:0] nib_i,
    output logic [6:0]       seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (nib_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan.sv
// 6-digit common-anode 7-segment scanner with frame-coherent snapshot and anti-ghost blanking.
// Latency: an/seg registered, one cycle behind div/idx/snap. Backpressure: none (free-running scan).
// Ports: clk, rst_n (async active-low); tm packed BCD {hr,mn,sd}; dp_mask live per-digit dp;
//        an active-low anodes; seg active-low {dp,g..a}; blink_mask only with SEG_SCAN_BLINK_EN.
// Optional macro SEG_SCAN_BLINK_EN adds blink_mask, a frame counter and a blink phase.
module seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 16
`ifdef SEG_SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [TM_W-1:0]       tm,
    input  logic [NUM_DIGITS-1:0] dp_mask,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            seg
);

    localparam int               DIV_W     = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]      div_q,  div_d;
    logic [IDX_W-1:0]      idx_q,  idx_d;
    logic [TM_W-1:0]       snap_q, snap_d;
    logic [NUM_DIGITS-1:0] an_q,   an_d;
    logic [7:0]            seg_q,  seg_d;

    logic       slot_end;
    logic       frame_end;
    logic       digit_off;
    logic [NIB_W-1:0] cur_nib;
    logic [6:0] cur_code;

    assign slot_end  = (div_q == DIV_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);

    // One decoder shared by all digits, fed by the nibble of the active slot.
    assign cur_nib = digit_nibble(snap_q, idx_q);

    bcd_to_seg u_dec (
        .nib_i (cur_nib),
        .seg_o (cur_code)
    );

`ifdef SEG_SCAN_BLINK_EN
    localparam int              FC_W    = $clog2(BLINK_FRAMES + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic            blink_on_q,  blink_on_d;

    // Phase flips on the frame end that completes BLINK_FRAMES frames.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_on_d  = blink_on_q;
        if (frame_end) begin
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign digit_off = !blink_on_q && blink_mask[idx_q];
`else
    assign digit_off = 1'b0;
`endif

    // Scan counters and the frame snapshot. tm is only captured as digit 5
    // finishes so a frame never mixes two time values.
    always_comb begin
        div_d  = div_q + 1'b1;
        idx_d  = idx_q;
        snap_d = snap_q;
        if (slot_end) begin
            div_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        if (frame_end) begin
            snap_d = tm;
        end
    end

    // Output word for the slot in progress. The leading blank cycles of every
    // slot keep all anodes off across each digit change (ghosting guard).
    always_comb begin
        an_d  = '1;
        seg_d = {1'b1, SEG_OFF};
        if (div_q >= BLANK_END) begin
            an_d = ~(NUM_DIGITS'(1) << idx_q);
            if (!digit_off) begin
                seg_d = {~dp_mask[idx_q], cur_code};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            idx_q  <= '0;
            snap_q <= '0;
            an_q   <= '1;
            seg_q  <= 8'hFF;
        end else begin
            div_q  <= div_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2.
// Each frame is 24 cycles: slot j occupies cycles 4j..4j+3, the first of which is blank.
module tb_seg_scan;

    logic        clk;
    logic        rst_n;
    logic [23:0] tm;
    logic [5:0]  dp_mask;
    logic [5:0]  an;
    logic [7:0]  seg;
`ifdef SEG_SCAN_BLINK_EN
    logic [5:0]  blink_mask;
`endif

    int total;
    int bad;

    seg_scan #(
        .SCAN_DIV     (4),
        .BLANK_CYC    (1)
`ifdef SEG_SCAN_BLINK_EN
        ,
        .BLINK_FRAMES (2)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tm         (tm),
        .dp_mask    (dp_mask),
`ifdef SEG_SCAN_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .an         (an),
        .seg        (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // 7-bit codes per digit, packed {d5,d4,d3,d2,d1,d0}.
    typedef logic [5:0][6:0] codes_t;

    typedef struct packed {
        logic [23:0] tm;
        logic [5:0]  dp;
        codes_t      code;
    } vec_t;

    task automatic check(input string tag, input int cyc,
                         input logic [5:0] exp_an, input logic [7:0] exp_seg);
        total++;
        if (an !== exp_an || seg !== exp_seg) begin
            bad++;
            $display("FAIL %s cyc=%0d got an=%h seg=%h want an=%h seg=%h",
                     tag, cyc, an, seg, exp_an, exp_seg);
        end
    endtask

    // Walks one whole frame, starting just after a negedge that precedes the
    // frame's first output edge. Optionally changes tm after cycle chg_cyc.
    task automatic run_frame(input codes_t code, input logic [5:0] off,
                             input int chg_cyc, input logic [23:0] chg_tm,
                             input string tag);
        logic [5:0] exp_an;
        logic [7:0] exp_seg;
        int         j;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk);
            @(negedge clk);
            j = c / 4;
            if (c % 4 == 0) begin
                exp_an  = 6'h3F;
                exp_seg = 8'hFF;
            end else begin
                exp_an  = ~(6'b000001 << j);
                exp_seg = off[j] ? 8'hFF : {~dp_mask[j], code[j]};
            end
            check(tag, c, exp_an, exp_seg);
            if (c == chg_cyc) tm = chg_tm;
        end
    endtask

    codes_t zeros, c123456, c235959, c888888, prev;
    vec_t   vecs [4];

    initial begin
        total = 0;
        bad   = 0;

        zeros   = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        c123456 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
        c235959 = {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10};
        c888888 = {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

        vecs[0] = {24'hAB0000, 6'b000000, {7'h3F, 7'h3F, 7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[1] = {24'h789012, 6'b000100, {7'h78, 7'h00, 7'h10, 7'h40, 7'h79, 7'h24}};
        vecs[2] = {24'hFEDC00, 6'b010010, {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h40, 7'h40}};
        vecs[3] = {24'h345678, 6'b100001, {7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}};

        rst_n   = 1'b0;
        tm      = 24'h123456;
        dp_mask = 6'b000000;
`ifdef SEG_SCAN_BLINK_EN
        blink_mask = 6'b000000;
`endif
        repeat (3) @(negedge clk);
        check("reset_values", 0, 6'h3F, 8'hFF);
        rst_n = 1'b1;

        // First frame after reset shows the zero snapshot, not tm.
        run_frame(zeros, 6'b0, -1, 24'h0, "frame0_zero");
        run_frame(c123456, 6'b0, -1, 24'h0, "frame1_123456");
        // tm changes during digit 2: the frame keeps the old snapshot.
        run_frame(c123456, 6'b0, 9, 24'h235959, "midframe_hold");

        prev = c235959;
        for (int i = 0; i < 4; i++) begin
            tm      = vecs[i].tm;
            dp_mask = vecs[i].dp;
            run_frame(prev, 6'b0, -1, 24'h0, $sformatf("vec%0d", i));
            prev = vecs[i].code;
        end
        run_frame(prev, 6'b0, -1, 24'h0, "vec_last");

        // Reset asserted while digit 3 is lit.
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("digit3_active", 13, 6'h37, {~dp_mask[3], prev[3]});
        rst_n = 1'b0;
        #1;
        check("async_reset", 0, 6'h3F, 8'hFF);
        @(posedge clk);
        @(negedge clk);
        check("reset_held", 0, 6'h3F, 8'hFF);
        rst_n = 1'b1;
        run_frame(zeros, 6'b0, -1, 24'h0, "post_reset_zero");
        run_frame(prev, 6'b0, -1, 24'h0, "post_reset_tm");

`ifdef SEG_SCAN_BLINK_EN
        tm         = 24'h888888;
        dp_mask    = 6'b000000;
        blink_mask = 6'b110000;
        rst_n      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(zeros,   6'b000000, -1, 24'h0, "blink_on0");
        run_frame(c888888, 6'b000000, -1, 24'h0, "blink_on1");
        run_frame(c888888, 6'b110000, -1, 24'h0, "blink_off2");
        run_frame(c888888, 6'b110000, -1, 24'h0, "blink_off3");
        run_frame(c888888, 6'b000000, -1, 24'h0, "blink_on4");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Display-side consumer of the 24-bit packed BCD time word {hr,mn,sd} produced by the display-select mux.
- Drives a 6-digit common-anode multiplexed 7-segment display: scan divider, digit rotation, frame-coherent snapshot, BCD-to-segment decode, anti-ghost blanking.
- Sits between the display mux and the board pins.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot; must be >= 2.
- BLANK_CYC, 16, cycles at the start of each slot with all anodes off; must be < SCAN_DIV.
- BLINK_FRAMES, 64, full frames per blink half-period; used only with BLINK_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- tm  in  24  packed BCD {hr[7:4],hr[3:0],mn[7:4],mn[3:0],sd[7:4],sd[3:0]}
- dp_mask  in  6  decimal point per digit, 1 = lit; bit k goes with digit k
- an  out  6  digit anodes, active-low; bit k drives digit k
- seg  out  8  active-low segments, {dp,g,f,e,d,c,b,a}
- blink_mask  in  6  present only with BLINK_EN; 1 = digit blinks

Behaviour:
- Decided interface: one clock, clk; reset rst_n, asynchronous, active-low.
- Reset values:
  - Outputs: an=6'h3F, seg=8'hFF.
  - Internal: div=0, idx=0, snap=24'h0, blink phase=on, frame counter=0.
- Digit mapping:
  - Digit k displays snap[4k+3:4k].
  - Digit 0 is the rightmost (seconds units); digit 5 is the hours tens.
- Scan divider:
  - div counts 0..SCAN_DIV-1, then wraps.
  - On the cycle where div==SCAN_DIV-1: idx advances by 1, wrapping 5->0.
  - On that same cycle, if idx==5, snap<=tm. A frame ends after digit 5.
- Frame coherence:
  - tm is sampled only at frame end. Changes mid-frame never tear the display.
  - The first frame after reset shows 000000.
- Output register:
  - an and seg are registered and computed from the current div, idx and snap, so they lag one cycle.
  - If div<BLANK_CYC: an=6'h3F and seg=8'hFF.
  - Otherwise: an = all ones except bit idx low; seg = {~dp_mask[idx], decode(nibble)}.
- Decode (active-low, g..a):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19
  - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10
  - Nibbles A..F show a dash: 7'h3F, only g lit.
- At most one anode is low on any cycle. Every anode change is preceded by at least BLANK_CYC all-off cycles.
- dp_mask is not snapshotted; it is sampled live every cycle.
- Reset asserted mid-slot: outputs go to reset values immediately; the scan restarts at digit 0, div=0.

Optional Feature:
- Macro: SEG_SCAN_BLINK_EN.
- When defined:
  - Port blink_mask and a frame counter are added.
  - The blink phase toggles after every BLINK_FRAMES complete frames.
  - During the off phase, any digit k with blink_mask[k]=1 drives seg=8'hFF in its slot; its anode timing is unchanged.
  - Used for setting-mode field indication.
- When not defined:
  - No blink_mask port and no frame counter.
  - Digits are never blanked beyond BLANK_CYC.

Decomposition:
- Package seg_pkg:
  - NUM_DIGITS=6
  - Segment code constants SEG_0..SEG_9, SEG_DASH, SEG_OFF
  - Width constant for the BCD nibble
- Sub-module bcd_to_seg: combinational 4-bit to 7-bit active-low decoder, instantiated once on the muxed nibble.

Test Plan (SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2):
- Reset release with tm=24'h123456 -> first frame shows 0 on every digit; second frame digit0 seg=8'h82 (6), digit5 seg=8'hF9 (1), with an low for exactly 3 of each 4-cycle slot.
- Change tm from 24'h123456 to 24'h235959 mid-frame (during digit 2) -> the rest of that frame still shows 123456; 235959 appears from digit 0 of the next frame.
- tm=24'hAB0000 -> digits 5 and 4 show seg=8'hBF (dash); digits 0-3 show 8'hC0.
- dp_mask=6'b000100 -> seg[7]=0 only during the digit-2 slot; an is never low on two bits and is 6'h3F on the first cycle of each slot.
- Assert rst_n low for 1 cycle while digit 3 is active -> an=6'h3F and seg=8'hFF in the same cycle; scan resumes at digit 0 with snap=0.
- With SEG_SCAN_BLINK_EN and blink_mask=6'b110000 -> digits 5 and 4 show seg=8'hFF for 2 frames, then normal for 2 frames; other digits are unaffected.
